pc_sequencer: RTL and testbench
===============================

PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 Parameter WIDTH, default 32, program-counter width; legal values 32..64.
REQ-002 Parameter RAS_DEPTH, default 4, return-address-stack entries; legal values are powers of two from 2 to 16.
REQ-003 Parameter RESET_VECTOR, default 0, PC value loaded on reset.
REQ-004 clk  input  1  single clock; all state updates on its rising edge.
REQ-005 rst_n  input  1  asynchronous reset, active-low.
REQ-006 stall  input  1  when high, holds all state for the cycle.
REQ-007 instr  input  32  current instruction word (MIPS encoding).
REQ-008 zero  input  1  ALU zero flag for the current branch compare.
REQ-009 rs_data  input  WIDTH  register-file rs value, used as the JR target.
REQ-010 pc  output  WIDTH  registered current PC.
REQ-011 link_addr  output  WIDTH  combinational pc+4, the JAL write-back value.
REQ-012 ras_top  output  WIDTH  top RAS entry; 0 when the stack is empty.
REQ-013 ras_count  output  clog2(RAS_DEPTH)+1  number of valid RAS entries.
REQ-014 ras_empty, ras_full  output  1 each  RAS status flags.
REQ-015 ras_hit, ras_miss  output  1 each  registered one-cycle pulses giving the JR prediction outcome.

Function
REQ-016 Decode SHALL use opcode=instr[31:26] and funct=instr[5:0]: J=000010, JAL=000011, BEQ=000100, BNE=000101, JR=opcode 000000 with funct 001000; all other encodings are sequential.
REQ-017 pc_plus4 SHALL equal pc+4, taken modulo 2^WIDTH; wrap-around from all-ones-minus-3 to 0 is legal.
REQ-018 The branch target SHALL equal pc_plus4 + (sign-extend(instr[15:0]) << 2), taken modulo 2^WIDTH.
REQ-019 The jump target SHALL equal {pc_plus4[WIDTH-1:28], instr[25:0], 2'b00}.
REQ-020 next_pc SHALL be selected as follows:
- BEQ with zero=1 -> branch target.
- BNE with zero=0 -> branch target.
- J or JAL -> jump target.
- JR -> rs_data, used unmodified.
- Otherwise -> pc_plus4.
REQ-021 When stall=0, pc SHALL load next_pc on the rising clock edge, giving one-cycle latency from instr to pc.
REQ-022 When stall=1, pc, the RAS, ras_hit and ras_miss SHALL all hold their values; no push or pop occurs.
REQ-023 JAL with stall=0 SHALL push pc_plus4 onto the RAS.
REQ-024 A push when the RAS is full SHALL overwrite the oldest entry as a circular buffer; ras_count stays at RAS_DEPTH.
REQ-025 JR with stall=0 and the RAS non-empty SHALL pop the top entry and decrement ras_count.
REQ-026 JR with the RAS empty SHALL leave the RAS unchanged.
REQ-027 JR SHALL raise ras_hit for exactly the next cycle when the RAS is non-empty and ras_top equals rs_data.
REQ-028 JR SHALL raise ras_miss for exactly the next cycle in all other cases, including an empty RAS; the pc update is unaffected.
REQ-029 For any instruction other than JR, ras_hit and ras_miss SHALL be 0 in the following cycle.
REQ-030 ras_empty SHALL be high exactly when ras_count=0.
REQ-031 ras_full SHALL be high exactly when ras_count=RAS_DEPTH.
REQ-032 JAL and JR are mutually exclusive by decode, so no simultaneous push and pop can occur.
REQ-033 The implementation SHALL be synthesizable with no latches; all next-state logic is combinational and all state lives in clk-edge registers.

Reset
REQ-034 When rst_n goes low, pc SHALL equal RESET_VECTOR immediately, without waiting for a clock edge.
REQ-035 Reset SHALL drive ras_count=0, ras_empty=1, ras_full=0, ras_hit=0, ras_miss=0 and ras_top=0.
REQ-036 Reset asserted mid-operation, including during stall or on a JAL/JR cycle, SHALL discard any pending update.
REQ-037 The first rising edge after rst_n rises SHALL load next_pc computed from pc=RESET_VECTOR.
REQ-038 The RAS storage contents are don't-care after reset; only ras_count defines which entries are valid.

Verification
REQ-039 Sequential: after reset with RESET_VECTOR=0 and no-op instructions, pc reads 0, 4, 8, 12 on successive edges; link_addr is always pc+4.
REQ-040 Branch: at pc=0x100, BEQ with imm=0xFFFF and zero=1 -> pc=0x100 next edge. Same with zero=0 -> pc=0x104. BNE with imm=2 and zero=0 -> pc=0x10C.
REQ-041 Call/return: at pc=0x0400_0010, JAL with instr[25:0]=0x40 -> pc=0x0000_0100, ras_top=0x0400_0014, ras_count=1. Then JR with rs_data=0x0400_0014 -> pc=0x0400_0014, ras_hit=1 for one cycle, ras_count=0.
REQ-042 Overflow: with RAS_DEPTH=4, five JALs from pc values 0x0, 0x10, 0x20, 0x30, 0x40 -> ras_full=1 and ras_count=4. Four JRs with matching rs_data -> pops 0x44, 0x34, 0x24, 0x14, each with ras_hit. A fifth JR -> ras_miss=1 and ras_count stays 0.
REQ-043 Stall/reset: JAL held with stall=1 for 3 cycles -> pc and ras_count unchanged. Dropping rst_n between clock edges -> pc=RESET_VECTOR at once and ras_count=0.
REQ-044 Wrap: with WIDTH=32 and pc=0xFFFF_FFFC, a sequential instruction -> pc=0x0000_0000.

Source files
------------

// File: rtl/pc_sequencer.sv
// pc_sequencer: MIPS-style next-PC selection with a circular return-address stack
// that predicts JR targets and reports hit/miss one cycle later.
module pc_sequencer #(
    parameter int                WIDTH        = 32,
    parameter int                RAS_DEPTH    = 4,
    parameter logic [WIDTH-1:0]  RESET_VECTOR = '0
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         stall,
    input  logic [31:0]                  instr,
    input  logic                         zero,
    input  logic [WIDTH-1:0]             rs_data,
    output logic [WIDTH-1:0]             pc,
    output logic [WIDTH-1:0]             link_addr,
    output logic [WIDTH-1:0]             ras_top,
    output logic [$clog2(RAS_DEPTH):0]   ras_count,
    output logic                         ras_empty,
    output logic                         ras_full,
    output logic                         ras_hit,
    output logic                         ras_miss
);
    localparam int AW = $clog2(RAS_DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] pc_q, pc_d, pc_plus4, br_tgt, jmp_tgt, next_pc;
    logic [WIDTH-1:0] mem_q [RAS_DEPTH];
    logic [WIDTH-1:0] mem_d [RAS_DEPTH];
    logic [AW-1:0]    sp_q, sp_d, top_idx;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             hit_q, hit_d, miss_q, miss_d;
    logic             is_j, is_jal, is_beq, is_bne, is_jr, push, pop, predict_ok;

    assign is_j     = instr[31:26] == 6'b000010;
    assign is_jal   = instr[31:26] == 6'b000011;
    assign is_beq   = instr[31:26] == 6'b000100;
    assign is_bne   = instr[31:26] == 6'b000101;
    assign is_jr    = instr[31:26] == 6'b000000 && instr[5:0] == 6'b001000;

    assign pc_plus4 = pc_q + WIDTH'(4);
    assign br_tgt   = pc_plus4 + {{(WIDTH-18){instr[15]}}, instr[15:0], 2'b00};
    assign jmp_tgt  = {pc_plus4[WIDTH-1:28], instr[25:0], 2'b00};

    // sp_q points at the next free slot, so the top entry sits just below it
    assign top_idx    = sp_q - 1'b1;
    assign ras_empty  = cnt_q == '0;
    assign ras_full   = cnt_q == CW'(RAS_DEPTH);
    assign ras_top    = ras_empty ? '0 : mem_q[top_idx];
    assign predict_ok = !ras_empty && ras_top == rs_data;

    assign pc         = pc_q;
    assign link_addr  = pc_plus4;
    assign ras_count  = cnt_q;
    assign ras_hit    = hit_q;
    assign ras_miss   = miss_q;

    always_comb begin
        next_pc = ((is_beq && zero) || (is_bne && !zero)) ? br_tgt :
                  (is_j || is_jal)                       ? jmp_tgt :
                  is_jr                                  ? rs_data : pc_plus4;
        push    = !stall && is_jal;
        pop     = !stall && is_jr && !ras_empty;
        pc_d    = stall ? pc_q : next_pc;
        mem_d   = mem_q;
        if (push) mem_d[sp_q] = pc_plus4;
        // a push on a full stack overwrites the oldest slot, count saturates
        sp_d    = push ? sp_q + 1'b1 : pop ? top_idx : sp_q;
        cnt_d   = push ? (ras_full ? cnt_q : cnt_q + 1'b1) : pop ? cnt_q - 1'b1 : cnt_q;
        hit_d   = stall ? hit_q  : is_jr && predict_ok;
        miss_d  = stall ? miss_q : is_jr && !predict_ok;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q   <= RESET_VECTOR;
            sp_q   <= '0;
            cnt_q  <= '0;
            hit_q  <= 1'b0;
            miss_q <= 1'b0;
        end else begin
            pc_q   <= pc_d;
            sp_q   <= sp_d;
            cnt_q  <= cnt_d;
            hit_q  <= hit_d;
            miss_q <= miss_d;
        end
    end

    always_ff @(posedge clk) mem_q <= mem_d;
endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer: directed bench for pc_sequencer at default parameters
// (WIDTH=32, RAS_DEPTH=4, RESET_VECTOR=0) with hand-computed expectations.
module tb_pc_sequencer;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        stall = 1'b0;
    logic [31:0] instr = '0;
    logic        zero = 1'b0;
    logic [31:0] rs_data = '0;
    logic [31:0] pc, link_addr, ras_top;
    logic [2:0]  ras_count;
    logic        ras_empty, ras_full, ras_hit, ras_miss;
    int          vectors = 0;
    int          miscompares = 0;

    pc_sequencer dut (
        .clk(clk), .rst_n(rst_n), .stall(stall), .instr(instr), .zero(zero),
        .rs_data(rs_data), .pc(pc), .link_addr(link_addr), .ras_top(ras_top),
        .ras_count(ras_count), .ras_empty(ras_empty), .ras_full(ras_full),
        .ras_hit(ras_hit), .ras_miss(ras_miss)
    );

    always #5 clk = ~clk;

    localparam logic [31:0] NOP = 32'h0000_0000;

    function automatic logic [31:0] op_j(input logic [25:0] idx);   return {6'b000010, idx}; endfunction
    function automatic logic [31:0] op_jal(input logic [25:0] idx); return {6'b000011, idx}; endfunction
    function automatic logic [31:0] op_beq(input logic [15:0] imm); return {6'b000100, 10'd0, imm}; endfunction
    function automatic logic [31:0] op_bne(input logic [15:0] imm); return {6'b000101, 10'd0, imm}; endfunction
    function automatic logic [31:0] op_jr();                         return {6'b000000, 5'd9, 15'd0, 6'b001000}; endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input logic [31:0] i, input logic z, input logic [31:0] rs, input logic st);
        instr = i; zero = z; rs_data = rs; stall = st;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_ras(input string tag, input logic [31:0] top, input logic [2:0] cnt,
                           input logic hit, input logic miss);
        chk({tag, ".top"}, 64'(ras_top), 64'(top));
        chk({tag, ".count"}, 64'(ras_count), 64'(cnt));
        chk({tag, ".empty"}, 64'(ras_empty), 64'(cnt == 0));
        chk({tag, ".full"}, 64'(ras_full), 64'(cnt == 4));
        chk({tag, ".hit"}, 64'(ras_hit), 64'(hit));
        chk({tag, ".miss"}, 64'(ras_miss), 64'(miss));
    endtask

    initial begin
        #2;
        chk("rst.pc", 64'(pc), 64'h0);
        chk_ras("rst", 32'h0, 3'd0, 1'b0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;

        step(NOP, 1'b0, 32'h0, 1'b0);
        chk("seq.pc4", 64'(pc), 64'h4);
        chk("seq.link4", 64'(link_addr), 64'h8);
        step(NOP, 1'b0, 32'h0, 1'b0);
        chk("seq.pc8", 64'(pc), 64'h8);
        step(NOP, 1'b0, 32'h0, 1'b0);
        chk("seq.pc12", 64'(pc), 64'hC);
        chk("seq.link12", 64'(link_addr), 64'h10);

        step(op_j(26'h40), 1'b0, 32'h0, 1'b0);
        chk("j.pc", 64'(pc), 64'h100);
        step(op_beq(16'hFFFF), 1'b1, 32'h0, 1'b0);
        chk("beq_taken.pc", 64'(pc), 64'h100);
        step(op_beq(16'hFFFF), 1'b0, 32'h0, 1'b0);
        chk("beq_not.pc", 64'(pc), 64'h104);
        step(op_beq(16'hFFFE), 1'b1, 32'h0, 1'b0);
        chk("beq_back.pc", 64'(pc), 64'h100);
        step(op_bne(16'h0002), 1'b0, 32'h0, 1'b0);
        chk("bne_taken.pc", 64'(pc), 64'h10C);
        step(op_bne(16'h0002), 1'b1, 32'h0, 1'b0);
        chk("bne_not.pc", 64'(pc), 64'h110);

        step(op_jr(), 1'b0, 32'h0400_0010, 1'b0);
        chk("jr_empty.pc", 64'(pc), 64'h0400_0010);
        chk_ras("jr_empty", 32'h0, 3'd0, 1'b0, 1'b1);
        step(op_jal(26'h40), 1'b0, 32'h0, 1'b0);
        chk("jal.pc", 64'(pc), 64'h100);
        chk_ras("jal", 32'h0400_0014, 3'd1, 1'b0, 1'b0);
        step(op_jr(), 1'b0, 32'h0400_0014, 1'b0);
        chk("ret.pc", 64'(pc), 64'h0400_0014);
        chk_ras("ret", 32'h0, 3'd0, 1'b1, 1'b0);
        step(NOP, 1'b0, 32'h0, 1'b0);
        chk_ras("ret_after", 32'h0, 3'd0, 1'b0, 1'b0);

        step(op_jr(), 1'b0, 32'h0, 1'b0);
        chk("to0.pc", 64'(pc), 64'h0);
        step(op_jal(26'h4), 1'b0, 32'h0, 1'b0);
        step(op_jal(26'h8), 1'b0, 32'h0, 1'b0);
        step(op_jal(26'hC), 1'b0, 32'h0, 1'b0);
        step(op_jal(26'h10), 1'b0, 32'h0, 1'b0);
        chk("jal4.pc", 64'(pc), 64'h40);
        chk_ras("jal4", 32'h34, 3'd4, 1'b0, 1'b0);
        step(op_jal(26'h80), 1'b0, 32'h0, 1'b0);
        chk("jal5.pc", 64'(pc), 64'h200);
        chk_ras("jal5", 32'h44, 3'd4, 1'b0, 1'b0);
        step(op_jr(), 1'b0, 32'h44, 1'b0);
        chk("pop1.pc", 64'(pc), 64'h44);
        chk_ras("pop1", 32'h34, 3'd3, 1'b1, 1'b0);
        step(op_jr(), 1'b0, 32'h34, 1'b0);
        chk_ras("pop2", 32'h24, 3'd2, 1'b1, 1'b0);
        step(op_jr(), 1'b0, 32'h24, 1'b0);
        chk_ras("pop3", 32'h14, 3'd1, 1'b1, 1'b0);
        step(op_jr(), 1'b0, 32'h14, 1'b0);
        chk("pop4.pc", 64'(pc), 64'h14);
        chk_ras("pop4", 32'h0, 3'd0, 1'b1, 1'b0);
        step(op_jr(), 1'b0, 32'h4, 1'b0);
        chk("pop5.pc", 64'(pc), 64'h4);
        chk_ras("pop5", 32'h0, 3'd0, 1'b0, 1'b1);

        for (int k = 0; k < 3; k++) begin
            step(op_jal(26'h40), 1'b0, 32'h0, 1'b1);
            chk("stall.pc", 64'(pc), 64'h4);
            chk_ras("stall", 32'h0, 3'd0, 1'b0, 1'b1);
        end
        step(op_jal(26'h40), 1'b0, 32'h0, 1'b0);
        chk("unstall.pc", 64'(pc), 64'h100);
        chk_ras("unstall", 32'h8, 3'd1, 1'b0, 1'b0);

        instr = op_jal(26'h80); stall = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("arst.pc", 64'(pc), 64'h0);
        chk_ras("arst", 32'h0, 3'd0, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        chk("arst_hold.pc", 64'(pc), 64'h0);
        chk("arst_hold.count", 64'(ras_count), 64'h0);
        @(negedge clk);
        rst_n = 1'b1;
        step(NOP, 1'b0, 32'h0, 1'b0);
        chk("post_rst.pc", 64'(pc), 64'h4);

        step(op_jr(), 1'b0, 32'hFFFF_FFFC, 1'b0);
        chk("wrap_pre.pc", 64'(pc), 64'hFFFF_FFFC);
        chk("wrap_pre.link", 64'(link_addr), 64'h0);
        step(NOP, 1'b0, 32'h0, 1'b0);
        chk("wrap.pc", 64'(pc), 64'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
